mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the processor's single memory port (cs/read_req/write_req/addrout/datatomem/datafrommem/mem_resp)
//  between two requesters: instruction fetch (read-only) and data load/store.
//  One transaction outstanding at a time; round-robin on contention; watchdog on a missing mem_resp.
//  Sits between the processor core and memory, inside processor_if's memory signal group.
// PARAMETERS
//  ADDR_W      14    memory word address width (matches addrout)
//  DATA_W      16    memory data width (matches datatomem/datafrommem)
//  TIMEOUT     64    cycles in BUSY without mem_resp before abort; legal range 2..255
// PORTS
//  clk           in   1       clock, all logic on posedge
//  reset_n       in   1       synchronous, active-low reset
//  fetch_req     in   1       fetch request level; hold with fetch_addr stable until fetch_gnt
//  fetch_addr    in   ADDR_W  fetch word address
//  fetch_gnt     out  1       1-cycle pulse: fetch request accepted
//  fetch_valid   out  1       1-cycle pulse: fetch_rdata valid or fetch aborted (see err)
//  fetch_rdata   out  DATA_W  fetch read data
//  data_req      in   1       data request level; hold with data_we/addr/wdata stable until data_gnt
//  data_we       in   1       1 = write, 0 = read
//  data_addr     in   ADDR_W  data word address
//  data_wdata    in   DATA_W  write data
//  data_gnt      out  1       1-cycle pulse: data request accepted
//  data_valid    out  1       1-cycle pulse: read data valid / write complete / abort
//  data_rdata    out  DATA_W  data read data (0 for writes)
//  err           out  1       qualifies the valid pulse of the same cycle: 1 = timed-out transaction
//  cs            out  1       memory chip select
//  read_req      out  1       memory read strobe
//  write_req     out  1       memory write strobe
//  addrout       out  ADDR_W  memory address
//  datatomem     out  DATA_W  memory write data
//  datafrommem   in   DATA_W  memory read data, sampled on the mem_resp cycle
//  mem_resp      in   1       memory completion, 1-cycle pulse
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, rr pointer = DATA (fetch wins the first tie), timeout counter 0.
//  FSM states:
//    IDLE: if any req at posedge -> pick winner, latch addr/we/wdata, go to BUSY.
//    BUSY: memory strobes driven from registers; on mem_resp -> RESP; if counter reaches TIMEOUT-1 -> RESP with err.
//    RESP: single cycle; valid (+err) pulses; return to IDLE.
//  Arbitration, only one req: that requester wins.
//    Both reqs: winner = requester != rr pointer.
//    rr pointer := winner on every grant.
//  Grant pulse is registered: asserted in the first BUSY cycle.
//    cs=1 in that same cycle, plus read_req=1 (fetch, or data with we=0) or write_req=1 (data with we=1).
//  Strobes, addrout and datatomem are held constant for all of BUSY; all go to 0 in RESP.
//    datatomem is 0 for reads.
//  mem_resp in BUSY: datafrommem is registered into the winner's rdata.
//    Winner's valid pulses in RESP; err=0.
//  Timeout: counter clears on entry to BUSY and increments each BUSY cycle.
//    At TIMEOUT-1 with no mem_resp: RESP with err=1, rdata=0.
//    mem_resp in the same cycle as the timeout wins (normal completion).
//  mem_resp outside BUSY is ignored (no output change).
//  Throughput: req sampled in IDLE cycle N -> gnt/cs in N+1.
//    mem_resp in N+1 -> valid in N+2 -> next gnt no earlier than N+4.
//  rdata outputs hold their value until the next valid for that requester.
//  A req deasserted before grant is simply not considered; a req deasserted after gnt has no effect.
//  reset_n=0 mid-transaction: transaction dropped, no valid issued, strobes 0 next cycle.
// STRUCTURE
//  tinyalu_pkg additions:
//    typedef logic [13:0] mem_addr_t
//    typedef logic [15:0] mem_data_t
//    typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY, ARB_RESP} arb_state_e
//    typedef enum logic {REQ_FETCH, REQ_DATA} arb_src_e
//  Single module: FSM, rr pointer and timeout counter are small and inline; no sub-module.
// TESTING
//  1. fetch_req only, addr 0x0010, mem_resp 3 cycles after cs, datafrommem 0xBEEF
//       -> fetch_gnt once, read_req held 3 cycles, fetch_valid with fetch_rdata=0xBEEF, err=0.
//  2. data_req we=1 addr 0x3FFF wdata 0x1234
//       -> write_req=1, addrout=0x3FFF, datatomem=0x1234 until mem_resp; data_valid, data_rdata=0.
//  3. Both reqs held continuously, mem_resp 1 cycle after cs
//       -> grants alternate F,D,F,D, starting with fetch after reset; no back-to-back same-source grants.
//  4. data read with no mem_resp, TIMEOUT=8
//       -> data_valid+err=1 exactly 8 cycles after data_gnt, data_rdata=0; next grant proceeds normally.
//  5. reset_n low for 1 cycle while in BUSY
//       -> cs/read_req/write_req 0 next cycle, no valid pulse; a later mem_resp is ignored.
//  6. mem_resp on the TIMEOUT-1 cycle, datafrommem 0x00A5 -> normal completion, rdata=0x00A5, err=0.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory-port arbiter: memory word/address types,
// arbiter FSM states and requester identifiers.
package mem_port_arbiter_pkg;

  typedef logic [13:0] mem_addr_t;
  typedef logic [15:0] mem_data_t;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    REQ_FETCH = 1'b0,
    REQ_DATA  = 1'b1
  } arb_src_e;

  // Width of the BUSY-cycle counter; covers the full legal TIMEOUT range.
  localparam int unsigned TMO_CNT_W = 8;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between instruction fetch (read-only) and
// data load/store. One transaction in flight at a time, round-robin on
// contention, and a watchdog that aborts a transaction lacking mem_resp.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W  = 14,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_gnt,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_rdata,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_gnt,
  output logic              data_valid,
  output logic [DATA_W-1:0] data_rdata,
  output logic              err,
  output logic              cs,
  output logic              read_req,
  output logic              write_req,
  output logic [ADDR_W-1:0] addrout,
  output logic [DATA_W-1:0] datatomem,
  input  logic [DATA_W-1:0] datafrommem,
  input  logic              mem_resp
);

  // Last BUSY cycle index before the watchdog fires.
  localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(TIMEOUT - 1);

  arb_state_e             state;
  arb_src_e               rr_ptr;
  arb_src_e               owner;
  logic                   owner_we;
  logic [TMO_CNT_W-1:0]   tmo_cnt;

  logic                   any_req;
  arb_src_e               winner;
  logic                   busy_done;

  // Pick the requester to grant: the lone requester, or on a tie the one
  // that was not granted last time.
  always_comb begin
    any_req = fetch_req | data_req;
    if (fetch_req && data_req) begin
      winner = (rr_ptr == REQ_FETCH) ? REQ_DATA : REQ_FETCH;
    end else if (fetch_req) begin
      winner = REQ_FETCH;
    end else begin
      winner = REQ_DATA;
    end
    busy_done = mem_resp | (tmo_cnt == TMO_LAST);
  end

  // Arbiter FSM with registered grant, memory strobes and completion outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= ARB_IDLE;
      rr_ptr      <= REQ_DATA;
      owner       <= REQ_FETCH;
      owner_we    <= 1'b0;
      tmo_cnt     <= '0;
      fetch_gnt   <= 1'b0;
      fetch_valid <= 1'b0;
      fetch_rdata <= '0;
      data_gnt    <= 1'b0;
      data_valid  <= 1'b0;
      data_rdata  <= '0;
      err         <= 1'b0;
      cs          <= 1'b0;
      read_req    <= 1'b0;
      write_req   <= 1'b0;
      addrout     <= '0;
      datatomem   <= '0;
    end else begin
      // Pulse outputs default low; only the transitions below raise them.
      fetch_gnt   <= 1'b0;
      data_gnt    <= 1'b0;
      fetch_valid <= 1'b0;
      data_valid  <= 1'b0;
      err         <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (any_req) begin
            state   <= ARB_BUSY;
            owner   <= winner;
            rr_ptr  <= winner;
            tmo_cnt <= '0;
            cs      <= 1'b1;
            if (winner == REQ_FETCH) begin
              fetch_gnt <= 1'b1;
              owner_we  <= 1'b0;
              read_req  <= 1'b1;
              write_req <= 1'b0;
              addrout   <= fetch_addr;
              datatomem <= '0;
            end else begin
              data_gnt  <= 1'b1;
              owner_we  <= data_we;
              read_req  <= ~data_we;
              write_req <= data_we;
              addrout   <= data_addr;
              datatomem <= data_we ? data_wdata : '0;
            end
          end else begin
            state <= ARB_IDLE;
          end
        end
        ARB_BUSY: begin
          if (busy_done) begin
            // A response arriving on the watchdog cycle still counts as success.
            state     <= ARB_RESP;
            cs        <= 1'b0;
            read_req  <= 1'b0;
            write_req <= 1'b0;
            addrout   <= '0;
            datatomem <= '0;
            err       <= ~mem_resp;
            if (owner == REQ_FETCH) begin
              fetch_valid <= 1'b1;
              fetch_rdata <= mem_resp ? datafrommem : '0;
            end else begin
              data_valid <= 1'b1;
              data_rdata <= (mem_resp && !owner_we) ? datafrommem : '0;
            end
          end else begin
            tmo_cnt <= tmo_cnt + TMO_CNT_W'(1);
          end
        end
        ARB_RESP: begin
          state <= ARB_IDLE;
        end
        default: begin
          state <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a transaction-level model is
// compared against every output on every cycle, plus directed literal checks.
module tb_mem_port_arbiter;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        fetch_req, data_req, data_we, mem_resp;
  logic [13:0] fetch_addr, data_addr, addrout;
  logic [15:0] data_wdata, datafrommem, fetch_rdata, data_rdata, datatomem;
  logic        fetch_gnt, fetch_valid, data_gnt, data_valid, err, cs, read_req, write_req;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit compare_on = 1'b0;

  mem_port_arbiter #(.ADDR_W(14), .DATA_W(16), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
    .fetch_valid(fetch_valid), .fetch_rdata(fetch_rdata),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_gnt(data_gnt), .data_valid(data_valid), .data_rdata(data_rdata),
    .err(err), .cs(cs), .read_req(read_req), .write_req(write_req),
    .addrout(addrout), .datatomem(datatomem), .datafrommem(datafrommem), .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // phase: 0 = no transaction, 1 = transaction on the memory port, 2 = completion cycle
  int          m_phase = 0;
  int          m_age   = 0;      // cycles since the grant
  bit          m_owner_data = 1'b0;
  bit          m_last_data  = 1'b1;
  bit          m_we = 1'b0;
  bit          m_timed_out = 1'b0;
  logic [13:0] m_addr  = '0;
  logic [15:0] m_wdata = '0;
  logic [15:0] m_frd   = '0;
  logic [15:0] m_drd   = '0;

  always @(posedge clk) begin
    if (!reset_n) begin
      m_phase = 0; m_age = 0; m_last_data = 1'b1; m_frd = '0; m_drd = '0; m_timed_out = 1'b0;
    end else if (m_phase == 0) begin
      if (fetch_req || data_req) begin
        m_owner_data = (fetch_req && data_req) ? !m_last_data : data_req;
        m_last_data  = m_owner_data;
        m_we    = m_owner_data ? data_we : 1'b0;
        m_addr  = m_owner_data ? data_addr : fetch_addr;
        m_wdata = data_wdata;
        m_age   = 0;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (mem_resp) begin
        m_timed_out = 1'b0;
        if (m_owner_data) m_drd = m_we ? 16'h0000 : datafrommem;
        else              m_frd = datafrommem;
        m_phase = 2;
      end else if (m_age == TMO - 1) begin
        m_timed_out = 1'b1;
        if (m_owner_data) m_drd = 16'h0000;
        else              m_frd = 16'h0000;
        m_phase = 2;
      end else begin
        m_age = m_age + 1;
      end
    end else begin
      m_phase = 0;
    end
  end

  // Compare every output against the model, away from the active edge.
  always @(negedge clk) begin
    if (compare_on) begin
      logic busy, resp;
      busy = (m_phase == 1);
      resp = (m_phase == 2);
      chk("cs",          {31'd0, cs},          {31'd0, busy});
      chk("read_req",    {31'd0, read_req},    {31'd0, busy && !m_we});
      chk("write_req",   {31'd0, write_req},   {31'd0, busy && m_we});
      chk("addrout",     {18'd0, addrout},     {18'd0, busy ? m_addr : 14'h0000});
      chk("datatomem",   {16'd0, datatomem},   {16'd0, (busy && m_we) ? m_wdata : 16'h0000});
      chk("fetch_gnt",   {31'd0, fetch_gnt},   {31'd0, busy && m_age == 0 && !m_owner_data});
      chk("data_gnt",    {31'd0, data_gnt},    {31'd0, busy && m_age == 0 && m_owner_data});
      chk("fetch_valid", {31'd0, fetch_valid}, {31'd0, resp && !m_owner_data});
      chk("data_valid",  {31'd0, data_valid},  {31'd0, resp && m_owner_data});
      chk("err",         {31'd0, err},         {31'd0, resp && m_timed_out});
      chk("fetch_rdata", {16'd0, fetch_rdata}, {16'd0, m_frd});
      chk("data_rdata",  {16'd0, data_rdata},  {16'd0, m_drd});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_gnt(output bit got_data, output int at_cyc);
    got_data = 1'b0;
    at_cyc   = -1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (fetch_gnt || data_gnt) begin
        got_data = data_gnt;
        at_cyc   = cyc;
        break;
      end
    end
    if (at_cyc < 0) chk("gnt_wait_expired", 32'd0, 32'd1);
  endtask

  task automatic wait_valid(output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (fetch_valid || data_valid) begin
        n = i;
        break;
      end
    end
    if (n < 0) chk("valid_wait_expired", 32'd0, 32'd1);
  endtask

  initial begin
    bit who;
    int g, gprev, n;
    bit seq [4];
    reset_n = 1'b0; fetch_req = 1'b0; data_req = 1'b0; data_we = 1'b0; mem_resp = 1'b0;
    fetch_addr = '0; data_addr = '0; data_wdata = '0; datafrommem = '0;
    tick();
    compare_on = 1'b1;
    chk("reset_cs", {31'd0, cs}, 32'd0);
    chk("reset_rdata", {16'd0, fetch_rdata}, 32'd0);
    reset_n = 1'b1;
    tick();

    // 1: fetch read, response on third port cycle
    fetch_req = 1'b1; fetch_addr = 14'h0010;
    wait_gnt(who, g);
    fetch_req = 1'b0;
    chk("t1_who", {31'd0, who}, 32'd0);
    chk("t1_addr", {18'd0, addrout}, 32'h0010);
    tick(); tick();
    mem_resp = 1'b1; datafrommem = 16'hBEEF;
    tick();
    mem_resp = 1'b0; datafrommem = 16'h0000;
    chk("t1_valid", {31'd0, fetch_valid}, 32'd1);
    chk("t1_rdata", {16'd0, fetch_rdata}, 32'h0000BEEF);
    chk("t1_err", {31'd0, err}, 32'd0);
    tick();

    // 2: data write at top address
    data_req = 1'b1; data_we = 1'b1; data_addr = 14'h3FFF; data_wdata = 16'h1234;
    wait_gnt(who, g);
    data_req = 1'b0;
    chk("t2_write_req", {31'd0, write_req}, 32'd1);
    chk("t2_addr", {18'd0, addrout}, 32'h3FFF);
    chk("t2_wdata", {16'd0, datatomem}, 32'h1234);
    tick();
    mem_resp = 1'b1; datafrommem = 16'h5555;
    tick();
    mem_resp = 1'b0;
    chk("t2_valid", {31'd0, data_valid}, 32'd1);
    chk("t2_rdata", {16'd0, data_rdata}, 32'd0);
    chk("t2_fetch_rdata_held", {16'd0, fetch_rdata}, 32'h0000BEEF);
    tick();

    // 3: contention after reset alternates F,D,F,D with 4-cycle spacing
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    data_we = 1'b0; data_addr = 14'h0200; fetch_addr = 14'h0100;
    fetch_req = 1'b1; data_req = 1'b1;
    gprev = -1;
    for (int k = 0; k < 4; k++) begin
      wait_gnt(who, g);
      seq[k] = who;
      if (k == 3) begin fetch_req = 1'b0; data_req = 1'b0; end
      if (gprev >= 0) chk("t3_spacing", g - gprev, 32'd4);
      gprev = g;
      tick();
      mem_resp = 1'b1; datafrommem = 16'(16'hA000 + k);
      tick();
      mem_resp = 1'b0;
    end
    chk("t3_g0", {31'd0, seq[0]}, 32'd0);
    chk("t3_g1", {31'd0, seq[1]}, 32'd1);
    chk("t3_g2", {31'd0, seq[2]}, 32'd0);
    chk("t3_g3", {31'd0, seq[3]}, 32'd1);
    chk("t3_drd", {16'd0, data_rdata}, 32'h0000A003);
    tick();

    // 4: data read with no response -> watchdog abort, then a normal fetch
    data_req = 1'b1; data_we = 1'b0; data_addr = 14'h0ABC;
    wait_gnt(who, g);
    data_req = 1'b0;
    wait_valid(n);
    chk("t4_latency", n, 32'd8);
    chk("t4_err", {31'd0, err}, 32'd1);
    chk("t4_rdata", {16'd0, data_rdata}, 32'd0);
    fetch_req = 1'b1; fetch_addr = 14'h0022;
    wait_gnt(who, g);
    fetch_req = 1'b0;
    mem_resp = 1'b1; datafrommem = 16'h7777;
    tick();
    mem_resp = 1'b0;
    chk("t4_next_err", {31'd0, err}, 32'd0);
    chk("t4_next_rdata", {16'd0, fetch_rdata}, 32'h7777);
    tick();

    // 5: reset in the middle of a transaction drops it
    data_req = 1'b1; data_we = 1'b0; data_addr = 14'h0123;
    wait_gnt(who, g);
    data_req = 1'b0;
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("t5_cs", {31'd0, cs}, 32'd0);
    chk("t5_read_req", {31'd0, read_req}, 32'd0);
    mem_resp = 1'b1; datafrommem = 16'hDEAD;
    tick();
    mem_resp = 1'b0;
    chk("t5_no_valid", {31'd0, data_valid | fetch_valid}, 32'd0);
    tick();
    chk("t5_rdata", {16'd0, data_rdata}, 32'd0);

    // 6: response on the last watchdog cycle completes normally
    fetch_req = 1'b1; fetch_addr = 14'h0300;
    wait_gnt(who, g);
    fetch_req = 1'b0;
    repeat (TMO - 1) tick();
    mem_resp = 1'b1; datafrommem = 16'h00A5;
    tick();
    mem_resp = 1'b0;
    chk("t6_valid", {31'd0, fetch_valid}, 32'd1);
    chk("t6_err", {31'd0, err}, 32'd0);
    chk("t6_rdata", {16'd0, fetch_rdata}, 32'h00A5);
    tick(); tick();

    compare_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
